// File: rtl/ibex_data_mem_responder.sv
// ---------------------------------------------------------------------------
// ibex_data_mem_responder
//   Responder end of the core data interface. Word-addressed SRAM model that
//   answers LSU load/store requests, with programmable grant wait states,
//   fixed response latency, an in-order response queue and error injection.
//
// Ports
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   data_req_i        request valid, held by the requester until gnt
//   data_gnt_o        request accepted this cycle (combinational from req)
//   data_rvalid_o     response valid, one per grant, in grant order
//   data_err_o        response carries an error (qualified by rvalid)
//   data_addr_i       byte address, [1:0] ignored for indexing
//   data_we_i         1 = store, 0 = load
//   data_be_i         store byte enables
//   data_wdata_i      lane-aligned store data
//   data_rdata_o      load data, 0 unless a good load response is presented
//   stall_i           back-pressure, forces gnt low
//   err_inject_i      sampled at gnt: error the transaction, suppress write
// ---------------------------------------------------------------------------
module ibex_data_mem_responder #(
    parameter int unsigned MEM_WORDS       = 1024,
    parameter logic [31:0] BASE_ADDR       = 32'h0001_0000,
    parameter int unsigned GNT_WAIT        = 0,
    parameter int unsigned RVALID_LAT      = 1,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        data_req_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic        data_err_o,
    input  logic [31:0] data_addr_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_wdata_i,
    output logic [31:0] data_rdata_o,
    input  logic        stall_i,
    input  logic        err_inject_i
);

    localparam int unsigned IDX_W  = $clog2(MEM_WORDS);
    localparam int unsigned WCNT_W = (GNT_WAIT < 1) ? 1 : $clog2(GNT_WAIT + 1);
    localparam int unsigned LAT_W  = $clog2(RVALID_LAT + 1);
    localparam int unsigned CNT_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(4 * MEM_WORDS);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    typedef struct packed {
        logic              err;
        logic              we;
        logic [31:0]       rdata;
        logic [LAT_W-1:0]  cnt;
    } rsp_t;

    state_e             state_q, state_d;
    logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
    rsp_t               q_q [MAX_OUTSTANDING];
    rsp_t               q_d [MAX_OUTSTANDING];
    logic [CNT_W-1:0]   count_q, count_d;

    logic               gnt_c;
    logic               head_pop_c;
    logic               can_accept_c;
    logic               in_range_c;
    logic               acc_err_c;
    logic [IDX_W-1:0]   mem_idx_c;
    logic [31:0]        rd_word_c;
    rsp_t               new_rsp_c;

    logic [31:0]        mem [MEM_WORDS];

    // Head entry's countdown has expired: it is presented and popped this cycle.
    assign head_pop_c   = (count_q != '0) && (q_q[0].cnt == '0);
    assign can_accept_c = ~stall_i & ((32'(count_q) < MAX_OUTSTANDING) | head_pop_c);

    // Address decode; BASE_ADDR is aligned to the array size, so the low
    // address bits index the array directly.
    assign in_range_c = (data_addr_i >= BASE_ADDR) && ({1'b0, data_addr_i} < END_ADDR);
    assign acc_err_c  = ~in_range_c | err_inject_i;
    assign mem_idx_c  = data_addr_i[IDX_W+1:2];
    assign rd_word_c  = mem[mem_idx_c];

    // Stored cnt is "cycles left after the next edge", so rvalid lands
    // exactly RVALID_LAT cycles after the grant.
    always_comb begin
        new_rsp_c       = '0;
        new_rsp_c.err   = acc_err_c;
        new_rsp_c.we    = data_we_i;
        new_rsp_c.rdata = (acc_err_c | data_we_i) ? 32'h0 : rd_word_c;
        new_rsp_c.cnt   = LAT_W'(RVALID_LAT - 1);
    end

    // Grant FSM
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        gnt_c   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (data_req_i) begin
                    if ((GNT_WAIT == 0) && can_accept_c) begin
                        gnt_c = 1'b1;
                    end else begin
                        state_d = WAIT;
                        wcnt_d  = WCNT_W'(1);
                    end
                end
            end
            WAIT: begin
                if (!data_req_i) begin
                    state_d = IDLE;
                    wcnt_d  = '0;
                end else if ((32'(wcnt_q) >= GNT_WAIT) && can_accept_c) begin
                    gnt_c   = 1'b1;
                    state_d = IDLE;
                    wcnt_d  = '0;
                end else if (32'(wcnt_q) < GNT_WAIT) begin
                    wcnt_d = wcnt_q + WCNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                wcnt_d  = '0;
            end
        endcase
    end

    // Response queue: age every entry, pop the head, then append the new grant.
    always_comb begin
        q_d     = q_q;
        count_d = count_q;
        for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
            if ((CNT_W'(i) < count_q) && (q_d[i].cnt != '0)) begin
                q_d[i].cnt = q_d[i].cnt - LAT_W'(1);
            end
        end
        if (head_pop_c) begin
            for (int i = 0; i < int'(MAX_OUTSTANDING) - 1; i++) begin
                q_d[i] = q_d[i+1];
            end
            q_d[MAX_OUTSTANDING-1] = '0;
            count_d = count_d - CNT_W'(1);
        end
        if (gnt_c) begin
            for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
                if (CNT_W'(i) == count_d) begin
                    q_d[i] = new_rsp_c;
                end
            end
            count_d = count_d + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
            count_q <= '0;
            q_q     <= '{default: '0};
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            count_q <= count_d;
            q_q     <= q_d;
        end
    end

    // SRAM array, not reset; written at the grant edge so a load granted
    // in the following cycle observes the store.
    always_ff @(posedge clk_i) begin
        if (gnt_c && data_we_i && !acc_err_c) begin
            for (int b = 0; b < 4; b++) begin
                if (data_be_i[b]) begin
                    mem[mem_idx_c][8*b +: 8] <= data_wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign data_gnt_o    = gnt_c;
    assign data_rvalid_o = head_pop_c;
    assign data_err_o    = head_pop_c & q_q[0].err;
    assign data_rdata_o  = (head_pop_c && !q_q[0].we && !q_q[0].err) ? q_q[0].rdata : 32'h0;

endmodule

// File: tb/tb_ibex_data_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_ibex_data_mem_responder
//   Directed bench for the data-memory responder. Four instances cover the
//   parameter corners: 0 = default timing, 1 = GNT_WAIT 2 / RVALID_LAT 3,
//   2 = RVALID_LAT 2 split accesses, 3 = single-entry queue back-pressure.
//   Inputs change 1ns after the rising edge; outputs are sampled on the
//   falling edge.
// ---------------------------------------------------------------------------
module tb_ibex_data_mem_responder;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        stall;
    logic        inject;

    logic        req    [4];
    logic        gnt    [4];
    logic        rvalid [4];
    logic        err    [4];
    logic [31:0] rdata  [4];

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    always #5 clk_i = ~clk_i;

    ibex_data_mem_responder #(.GNT_WAIT(0), .RVALID_LAT(1), .MAX_OUTSTANDING(2)) u_dut0 (
        .clk_i(clk_i), .rst_ni(rst_ni), .data_req_i(req[0]), .data_gnt_o(gnt[0]),
        .data_rvalid_o(rvalid[0]), .data_err_o(err[0]), .data_addr_i(addr),
        .data_we_i(we), .data_be_i(be), .data_wdata_i(wdata), .data_rdata_o(rdata[0]),
        .stall_i(stall), .err_inject_i(inject));

    ibex_data_mem_responder #(.GNT_WAIT(2), .RVALID_LAT(3), .MAX_OUTSTANDING(2)) u_dut1 (
        .clk_i(clk_i), .rst_ni(rst_ni), .data_req_i(req[1]), .data_gnt_o(gnt[1]),
        .data_rvalid_o(rvalid[1]), .data_err_o(err[1]), .data_addr_i(addr),
        .data_we_i(we), .data_be_i(be), .data_wdata_i(wdata), .data_rdata_o(rdata[1]),
        .stall_i(stall), .err_inject_i(inject));

    ibex_data_mem_responder #(.GNT_WAIT(0), .RVALID_LAT(2), .MAX_OUTSTANDING(2)) u_dut2 (
        .clk_i(clk_i), .rst_ni(rst_ni), .data_req_i(req[2]), .data_gnt_o(gnt[2]),
        .data_rvalid_o(rvalid[2]), .data_err_o(err[2]), .data_addr_i(addr),
        .data_we_i(we), .data_be_i(be), .data_wdata_i(wdata), .data_rdata_o(rdata[2]),
        .stall_i(stall), .err_inject_i(inject));

    ibex_data_mem_responder #(.GNT_WAIT(0), .RVALID_LAT(3), .MAX_OUTSTANDING(1)) u_dut3 (
        .clk_i(clk_i), .rst_ni(rst_ni), .data_req_i(req[3]), .data_gnt_o(gnt[3]),
        .data_rvalid_o(rvalid[3]), .data_err_o(err[3]), .data_addr_i(addr),
        .data_we_i(we), .data_be_i(be), .data_wdata_i(wdata), .data_rdata_o(rdata[3]),
        .stall_i(stall), .err_inject_i(inject));

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    endtask

    // Advance to the next cycle's drive point.
    task automatic next_cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic sample();
        @(negedge clk_i);
    endtask

    task automatic drive(input int idx, input logic r, input logic w,
                         input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
        req[idx] = r;
        we       = w;
        addr     = a;
        be       = b;
        wdata    = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni = 1'b0;
        for (int i = 0; i < 4; i++) req[i] = 1'b0;
        addr = '0; we = 1'b0; be = 4'h0; wdata = '0; stall = 1'b0; inject = 1'b0;
        repeat (3) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        sample();
        check_eq("rst_gnt",    32'(gnt[0]),    32'h0);
        check_eq("rst_rvalid", 32'(rvalid[0]), 32'h0);
        check_eq("rst_err",    32'(err[0]),    32'h0);
        check_eq("rst_rdata",  rdata[0],       32'h0);

        // ---- aligned store then load, same-cycle grant ----
        next_cyc(); drive(0, 1, 1, 32'h0001_0010, 4'hF, 32'hDEAD_BEEF);
        sample();   check_eq("st_gnt", 32'(gnt[0]), 32'h1);
                    check_eq("st_no_rvalid", 32'(rvalid[0]), 32'h0);
        next_cyc(); drive(0, 1, 0, 32'h0001_0010, 4'hF, 32'h0);
        sample();   check_eq("ld_gnt", 32'(gnt[0]), 32'h1);
                    check_eq("st_rsp_rvalid", 32'(rvalid[0]), 32'h1);
                    check_eq("st_rsp_rdata", rdata[0], 32'h0);
        next_cyc(); drive(0, 0, 0, 32'h0, 4'h0, 32'h0);
        sample();   check_eq("ld_rvalid", 32'(rvalid[0]), 32'h1);
                    check_eq("ld_rdata", rdata[0], 32'hDEAD_BEEF);
                    check_eq("ld_err", 32'(err[0]), 32'h0);
                    check_eq("idle_gnt", 32'(gnt[0]), 32'h0);
        next_cyc();
        sample();   check_eq("ld_rvalid_once", 32'(rvalid[0]), 32'h0);

        // ---- low address bits ignored ----
        next_cyc(); drive(0, 1, 0, 32'h0001_0013, 4'h0, 32'h0);
        next_cyc(); drive(0, 0, 0, 32'h0, 4'h0, 32'h0);
        sample();   check_eq("unaligned_rdata", rdata[0], 32'hDEAD_BEEF);

        // ---- byte lane merge ----
        next_cyc(); drive(0, 1, 1, 32'h0001_0020, 4'hF, 32'h1122_3344);
        next_cyc(); drive(0, 1, 1, 32'h0001_0020, 4'b0100, 32'hAABB_CCDD);
        sample();   check_eq("be_st2_gnt", 32'(gnt[0]), 32'h1);
        next_cyc(); drive(0, 1, 0, 32'h0001_0020, 4'h0, 32'h0);
        next_cyc(); drive(0, 0, 0, 32'h0, 4'h0, 32'h0);
        sample();   check_eq("be_rdata", rdata[0], 32'h11BB_3344);

        // ---- out of range below base and at end ----
        next_cyc(); drive(0, 1, 0, 32'h0000_0000, 4'h0, 32'h0);
        sample();   check_eq("oor_gnt", 32'(gnt[0]), 32'h1);
        next_cyc(); drive(0, 1, 0, 32'h0001_1000, 4'h0, 32'h0);
        sample();   check_eq("oor_lo_err", 32'(err[0]), 32'h1);
                    check_eq("oor_lo_rdata", rdata[0], 32'h0);
        next_cyc(); drive(0, 0, 0, 32'h0, 4'h0, 32'h0);
        sample();   check_eq("oor_hi_err", 32'(err[0]), 32'h1);
                    check_eq("oor_hi_rvalid", 32'(rvalid[0]), 32'h1);

        // ---- last word in range ----
        next_cyc(); drive(0, 1, 1, 32'h0001_0FFC, 4'hF, 32'h1234_5678);
        next_cyc(); drive(0, 1, 0, 32'h0001_0FFC, 4'h0, 32'h0);
        next_cyc(); drive(0, 0, 0, 32'h0, 4'h0, 32'h0);
        sample();   check_eq("last_word_err", 32'(err[0]), 32'h0);
                    check_eq("last_word_rdata", rdata[0], 32'h1234_5678);

        // ---- error injection suppresses the write ----
        next_cyc(); drive(0, 1, 1, 32'h0001_0010, 4'hF, 32'h5555_5555); inject = 1'b1;
        sample();   check_eq("inj_gnt", 32'(gnt[0]), 32'h1);
        next_cyc(); drive(0, 1, 0, 32'h0001_0010, 4'h0, 32'h0); inject = 1'b0;
        sample();   check_eq("inj_err", 32'(err[0]), 32'h1);
                    check_eq("inj_rdata", rdata[0], 32'h0);
        next_cyc(); drive(0, 0, 0, 32'h0, 4'h0, 32'h0);
        sample();   check_eq("inj_unchanged", rdata[0], 32'hDEAD_BEEF);
                    check_eq("inj_ld_err", 32'(err[0]), 32'h0);

        // ---- stall holds off the grant ----
        next_cyc(); drive(0, 1, 0, 32'h0001_0010, 4'h0, 32'h0); stall = 1'b1;
        sample();   check_eq("stall_gnt", 32'(gnt[0]), 32'h0);
        next_cyc(); stall = 1'b0;
        sample();   check_eq("unstall_gnt", 32'(gnt[0]), 32'h1);
        next_cyc(); drive(0, 0, 0, 32'h0, 4'h0, 32'h0);
        sample();   check_eq("stall_ld_rdata", rdata[0], 32'hDEAD_BEEF);

        // ---- wait states: gnt c2, rvalid c5 ----
        next_cyc(); drive(1, 1, 1, 32'h0001_0040, 4'hF, 32'h0000_0001);
        sample();   check_eq("ws_gnt_c0", 32'(gnt[1]), 32'h0);
        next_cyc();
        sample();   check_eq("ws_gnt_c1", 32'(gnt[1]), 32'h0);
        next_cyc();
        sample();   check_eq("ws_gnt_c2", 32'(gnt[1]), 32'h1);
        next_cyc(); req[1] = 1'b0;
        sample();   check_eq("ws_rvalid_c3", 32'(rvalid[1]), 32'h0);
        next_cyc();
        sample();   check_eq("ws_rvalid_c4", 32'(rvalid[1]), 32'h0);
        next_cyc();
        sample();   check_eq("ws_rvalid_c5", 32'(rvalid[1]), 32'h1);
                    check_eq("ws_err_c5", 32'(err[1]), 32'h0);
        next_cyc();
        sample();   check_eq("ws_rvalid_c6", 32'(rvalid[1]), 32'h0);

        // ---- wait states with stall in c2: gnt c3, rvalid c6 ----
        next_cyc(); drive(1, 1, 1, 32'h0001_0044, 4'hF, 32'h0000_0002);
        next_cyc();
        next_cyc(); stall = 1'b1;
        sample();   check_eq("wss_gnt_c2", 32'(gnt[1]), 32'h0);
        next_cyc(); stall = 1'b0;
        sample();   check_eq("wss_gnt_c3", 32'(gnt[1]), 32'h1);
        next_cyc(); req[1] = 1'b0;
        next_cyc();
        sample();   check_eq("wss_rvalid_c5", 32'(rvalid[1]), 32'h0);
        next_cyc();
        sample();   check_eq("wss_rvalid_c6", 32'(rvalid[1]), 32'h1);

        // ---- req dropped before gnt restarts the wait ----
        next_cyc(); drive(1, 1, 1, 32'h0001_0048, 4'hF, 32'h0000_0003);
        next_cyc(); req[1] = 1'b0;
        next_cyc(); req[1] = 1'b1;
        sample();   check_eq("drop_gnt_c2", 32'(gnt[1]), 32'h0);
        next_cyc();
        sample();   check_eq("drop_gnt_c3", 32'(gnt[1]), 32'h0);
        next_cyc();
        sample();   check_eq("drop_gnt_c4", 32'(gnt[1]), 32'h1);
        next_cyc(); req[1] = 1'b0;
        repeat (4) next_cyc();

        // ---- single-entry queue blocks until the head pops ----
        next_cyc(); drive(3, 1, 1, 32'h0001_0030, 4'hF, 32'hA0A0_A0A0);
        sample();   check_eq("full_gnt_c0", 32'(gnt[3]), 32'h1);
        next_cyc();
        sample();   check_eq("full_gnt_c1", 32'(gnt[3]), 32'h0);
        next_cyc();
        sample();   check_eq("full_gnt_c2", 32'(gnt[3]), 32'h0);
        next_cyc();
        sample();   check_eq("full_gnt_c3", 32'(gnt[3]), 32'h1);
                    check_eq("full_rvalid_c3", 32'(rvalid[3]), 32'h1);
        next_cyc(); req[3] = 1'b0;
        sample();   check_eq("full_rvalid_c4", 32'(rvalid[3]), 32'h0);
        next_cyc();
        next_cyc();
        sample();   check_eq("full_rvalid_c6", 32'(rvalid[3]), 32'h1);

        // ---- split access, RVALID_LAT=2 ----
        next_cyc(); drive(2, 1, 1, 32'h0001_0010, 4'hF, 32'hA5A5_0001);
        next_cyc(); drive(2, 1, 1, 32'h0001_0014, 4'hF, 32'h5A5A_0002);
        next_cyc(); req[2] = 1'b0;
        repeat (3) next_cyc();
        drive(2, 1, 0, 32'h0001_0010, 4'h0, 32'h0);
        sample();   check_eq("split_gnt_c0", 32'(gnt[2]), 32'h1);
        next_cyc(); drive(2, 1, 0, 32'h0001_0014, 4'h0, 32'h0);
        sample();   check_eq("split_gnt_c1", 32'(gnt[2]), 32'h1);
                    check_eq("split_rvalid_c1", 32'(rvalid[2]), 32'h0);
        next_cyc(); drive(2, 1, 0, 32'h0001_0010, 4'h0, 32'h0);
        sample();   check_eq("split_gnt_c2_pop", 32'(gnt[2]), 32'h1);
                    check_eq("split_rdata_c2", rdata[2], 32'hA5A5_0001);
        next_cyc(); req[2] = 1'b0;
        sample();   check_eq("split_rdata_c3", rdata[2], 32'h5A5A_0002);
        next_cyc();
        sample();   check_eq("split_rdata_c4", rdata[2], 32'hA5A5_0001);
        next_cyc();
        sample();   check_eq("split_rvalid_c5", 32'(rvalid[2]), 32'h0);

        // ---- reset with two responses queued ----
        next_cyc(); drive(2, 1, 0, 32'h0001_0010, 4'h0, 32'h0);
        next_cyc(); drive(2, 1, 0, 32'h0001_0014, 4'h0, 32'h0);
        sample();   req[2] = 1'b0; rst_ni = 1'b0;
        #1;         check_eq("rst_mid_rvalid", 32'(rvalid[2]), 32'h0);
        next_cyc();
        next_cyc(); rst_ni = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sample();
            check_eq("post_rst_rvalid", 32'(rvalid[2]), 32'h0);
            next_cyc();
        end
        drive(2, 1, 0, 32'h0001_0014, 4'h0, 32'h0);
        sample();   check_eq("post_rst_gnt", 32'(gnt[2]), 32'h1);
        next_cyc(); req[2] = 1'b0;
        sample();   check_eq("post_rst_rvalid_c1", 32'(rvalid[2]), 32'h0);
        next_cyc();
        sample();   check_eq("post_rst_rdata", rdata[2], 32'h5A5A_0002);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
